key_expand_ctrl: RTL and testbench

Sequencer for AES-128 key expansion. It loads a 128-bit cipher key and steps the round counter. It drives the address of the registered 11-entry round-constant ROM and combines each returned constant with an external SubWord result to form the next round key. Round keys 0..10 go out in order over a valid/ready stream to the cipher datapath or a round-key store.

---
 rtl/aes_pkg.sv | 15 +
 rtl/key_round_step.sv | 32 +++
 rtl/key_expand_ctrl.sv | 100 ++++++++++
 tb/tb_key_expand_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion constants and the sequencer state type.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RCON_AW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StCalc
    } kx_state_e;

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-schedule step: RotWord of w3 for the external SubWord, and the
// XOR chain that turns the current key plus SubWord/Rcon into the next round key.
module key_round_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0]  key_i,
    input  logic [WORD_W-1:0] sw_out_i,
    input  logic [WORD_W-1:0] rcon_i,
    output logic [WORD_W-1:0] rot_o,
    output logic [KEY_W-1:0]  key_next_o
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] temp;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign w0 = key_i[127:96];
    assign w1 = key_i[95:64];
    assign w2 = key_i[63:32];
    assign w3 = key_i[31:0];

    assign rot_o = {w3[23:0], w3[31:24]};

    assign temp = sw_out_i ^ rcon_i;
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    assign key_next_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion sequencer: emits round keys 0..10 over a valid/ready stream,
// driving an external registered Rcon ROM and a combinational SubWord.
module key_expand_ctrl
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KEY_W-1:0]     key_in,
    output logic                 busy,
    output logic                 done,
    output logic [RCON_AW-1:0]   rcon_addr,
    input  logic [WORD_W-1:0]    rcon_dout,
    output logic [WORD_W-1:0]    sw_in,
    input  logic [WORD_W-1:0]    sw_out,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [RCON_AW-1:0]   rk_idx,
    output logic [KEY_W-1:0]     rk
);

    localparam logic [RCON_AW-1:0] LastRound = RCON_AW'(NR);

    kx_state_e            state_q, state_d;
    logic [RCON_AW-1:0]   round_q, round_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 done_q, done_d;
    logic [KEY_W-1:0]     key_next;
    logic                 last_round;

    assign last_round = (round_q == LastRound);

    key_round_step u_step (
        .key_i      (key_q),
        .sw_out_i   (sw_out),
        .rcon_i     (rcon_dout),
        .rot_o      (sw_in),
        .key_next_o (key_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= '0;
            key_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (rk_ready) begin
                    if (last_round) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                key_d   = key_next;
                round_d = round_q + 4'd1;
                state_d = StEmit;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address runs one round ahead so the registered ROM has Rcon ready in CALC.
    always_comb begin
        busy      = (state_q != StIdle);
        rk_valid  = (state_q == StEmit);
        rk        = key_q;
        rk_idx    = round_q;
        done      = done_q;
        rcon_addr = '0;
        if (state_q != StIdle && !last_round) begin
            rcon_addr = round_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl with behavioural Rcon ROM and S-box models.
module tb_key_expand_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [3:0]   rcon_addr;
    logic [31:0]  rcon_dout;
    logic [31:0]  sw_in;
    logic [31:0]  sw_out;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk;

    int n_cmp = 0;
    int n_err = 0;
    int n_got;
    int dc;
    logic [127:0] got [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] SBOX [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        row = SBOX[b[7:4]];
        return row[8 * (15 - int'(b[3:0])) +: 8];
    endfunction

    function automatic logic [7:0] rc(input logic [3:0] a);
        case (a)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign sw_out = {sb(sw_in[31:24]), sb(sw_in[23:16]), sb(sw_in[15:8]), sb(sw_in[7:0])};

    always_ff @(posedge clk) rcon_dout <= {rc(rcon_addr), 24'h0};

    key_expand_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .rcon_addr (rcon_addr),
        .rcon_dout (rcon_dout),
        .sw_in     (sw_in),
        .sw_out    (sw_out),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_idx    (rk_idx),
        .rk        (rk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller raises start at a negedge; returns at the negedge where done is seen.
    task automatic run_exp(input int max_stall, input bit inject, output int done_cyc);
        int           stall;
        bit           pending;
        logic [127:0] prv_rk;
        logic [3:0]   prv_idx;
        logic [3:0]   exp_a;
        pending  = 0;
        stall    = 0;
        prv_rk   = '0;
        prv_idx  = '0;
        n_got    = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
            chk("addr_range", 128'(rcon_addr <= 4'd10), 128'(1'b1));
            if (rk_valid) begin
                if (pending) begin
                    chk("rk_hold", rk, prv_rk);
                    chk("idx_hold", 128'(rk_idx), 128'(prv_idx));
                end else begin
                    stall = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
                end
                exp_a = (rk_idx < 4'd10) ? rk_idx + 4'd1 : 4'd0;
                chk("addr_emit", 128'(rcon_addr), 128'(exp_a));
                rk_ready = (stall == 0);
                if (stall > 0) stall--;
                if (inject && rk_idx == 4'd3 && !pending) begin
                    start    = 1'b1;
                    key_in   = ~key_in;
                    rk_ready = 1'b0;
                end
                if (rk_ready) begin
                    if (n_got < 11) got[n_got] = rk;
                    chk("rk_idx", 128'(rk_idx), 128'(n_got));
                    n_got++;
                    pending = 0;
                end else begin
                    pending = 1;
                    prv_rk  = rk;
                    prv_idx = rk_idx;
                end
            end else begin
                chk("busy_calc", 128'(busy), 128'(1'b1));
                chk("addr_calc", 128'(rcon_addr), 128'(n_got));
                rk_ready = (max_stall > 0) ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 128'(rk_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_addr", 128'(rcon_addr), 128'(4'd0));
        chk("rst_idx", 128'(rk_idx), 128'(4'd0));
        chk("rst_rk", rk, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 128'(busy), 128'(1'b0));

        // FIPS-197 key, consumer always ready.
        start    = 1'b1;
        key_in   = FIPS_KEY;
        rk_ready = 1'b1;
        run_exp(0, 1'b0, dc);
        chk("fips_done_cycle", 128'(dc), 128'(22));
        chk("fips_count", 128'(n_got), 128'(11));
        for (int i = 0; i < 11; i++) chk($sformatf("fips_rk%0d", i), got[i], FIPS_RK[i]);
        chk("done_idle_busy", 128'(busy), 128'(1'b0));
        chk("done_idle_valid", 128'(rk_valid), 128'(1'b0));
        chk("done_idle_addr", 128'(rcon_addr), 128'(4'd0));

        // Restart in the done cycle with the all-zero key.
        start  = 1'b1;
        key_in = '0;
        run_exp(0, 1'b0, dc);
        chk("zero_done_cycle", 128'(dc), 128'(22));
        chk("zero_count", 128'(n_got), 128'(11));
        chk("zero_rk0", got[0], 128'h0);
        chk("zero_rk1", got[1], 128'h62636363626363636263636362636363);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'(1'b0));

        // Asynchronous reset during the CALC that builds round key 5.
        start    = 1'b1;
        key_in   = FIPS_KEY;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("calc5_valid", 128'(rk_valid), 128'(1'b0));
        chk("calc5_busy", 128'(busy), 128'(1'b1));
        chk("calc5_addr", 128'(rcon_addr), 128'(4'd5));
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(rk_valid), 128'(1'b0));
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_addr", 128'(rcon_addr), 128'(4'd0));
        chk("arst_rk", rk, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 128'(rk_valid), 128'(1'b0));
        chk("post_rst_busy", 128'(busy), 128'(1'b0));

        // Backpressure plus a stray start during round 3.
        start  = 1'b1;
        key_in = FIPS_KEY;
        run_exp(5, 1'b1, dc);
        chk("bp_done_seen", 128'(dc > 0), 128'(1'b1));
        chk("bp_count", 128'(n_got), 128'(11));
        for (int i = 0; i < 11; i++) chk($sformatf("bp_rk%0d", i), got[i], FIPS_RK[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
